// File: rtl/ahb_gpio_irq_port_if.sv
// AHB-Lite slave-side signal bundle for the GPIO/interrupt port.
interface ahb_gpio_irq_port_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic        HREADY;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADYOUT;

  modport master (output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA,
                  input  HRDATA, HREADYOUT);
  modport slave  (input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA,
                  output HRDATA, HREADYOUT);
endinterface

// File: rtl/ahb_gpio_irq_port.sv
// AHB-Lite GPIO port: per-pin synchroniser, edge/level interrupt detect, W1S/W1C output control.
module ahb_gpio_irq_lane #(
  parameter int SYNC_STAGES = 2
) (
  input  logic HCLK,
  input  logic HRESETn,
  input  logic din,
  input  logic armed,
  input  logic oe,
  input  logic edge_mode,
  input  logic pol,
  input  logic both,
  input  logic icr,
  output logic data,
  output logic ris
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic prev_q, edge_q, lvl_q, rise, fall, hit;

  assign data = sync_q[SYNC_STAGES-1];
  assign rise = data & ~prev_q;
  assign fall = ~data & prev_q;
  assign hit  = armed & ~oe & edge_mode & (both ? (rise | fall) : (pol ? rise : fall));
  assign ris  = edge_q | lvl_q;

  // Set beats clear; leaving edge mode drops any stale sticky bit.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      edge_q <= 1'b0;
      lvl_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q <= data;
      edge_q <= hit | (edge_q & edge_mode & ~icr);
      lvl_q  <= armed & ~oe & ~edge_mode & (data == pol);
    end
  end
endmodule

module ahb_gpio_irq_port #(
  parameter int SZ          = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  ahb_gpio_irq_port_if.slave  ahb,
  output logic                IRQ,
  input  logic [SZ-1:0]       GPIO_DIN,
  output logic [SZ-1:0]       GPIO_DOUT,
  output logic [SZ-1:0]       GPIO_PU,
  output logic [SZ-1:0]       GPIO_PD,
  output logic [SZ-1:0]       GPIO_OE
);
  logic [7:0]    addr_q;
  logic          wr_q;
  logic [SZ-1:0] out_q, pu_q, pd_q, oe_q, im_q, is_q, iev_q, ibe_q;
  logic [SZ-1:0] data, ris, mis, icr, wdata, val;
  logic [SYNC_STAGES:0] vld_pipe;
  logic          armed, irq_q, unmapped;
  logic [31:0]   rdata;
  logic          unused_bus;

  // Edge detection stays off until the synchroniser and prev flops hold real pad samples.
  assign armed = vld_pipe[SYNC_STAGES];
  assign wdata = ahb.HWDATA[SZ-1:0];
  assign icr   = (wr_q && addr_q == 8'h2C) ? wdata : '0;
  assign mis   = ris & im_q;
  assign unused_bus = ^{ahb.HSIZE, ahb.HADDR[31:8], ahb.HTRANS[0], ahb.HWDATA};

  ahb_gpio_irq_lane #(.SYNC_STAGES(SYNC_STAGES)) u_lane [SZ-1:0] (
    .HCLK(HCLK), .HRESETn(HRESETn), .din(GPIO_DIN), .armed(armed), .oe(oe_q),
    .edge_mode(is_q), .pol(iev_q), .both(ibe_q), .icr(icr), .data(data), .ris(ris)
  );

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_q   <= '0;
      wr_q     <= 1'b0;
      out_q    <= '0;
      pu_q     <= '0;
      pd_q     <= '0;
      oe_q     <= '0;
      im_q     <= '0;
      is_q     <= '0;
      iev_q    <= '0;
      ibe_q    <= '0;
      irq_q    <= 1'b0;
      vld_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[SYNC_STAGES-1:0], 1'b1};
      irq_q    <= |mis;
      if (ahb.HREADY) begin
        wr_q <= ahb.HSEL & ahb.HTRANS[1] & ahb.HWRITE;
        if (ahb.HSEL && ahb.HTRANS[1]) addr_q <= ahb.HADDR[7:0];
      end
      if (wr_q) begin
        case (addr_q)
          8'h04: out_q <= wdata;
          8'h08: pu_q  <= wdata;
          8'h0C: pd_q  <= wdata;
          8'h10: oe_q  <= wdata;
          8'h14: im_q  <= wdata;
          8'h18: is_q  <= wdata;
          8'h1C: iev_q <= wdata;
          8'h20: ibe_q <= wdata;
          8'h30: out_q <= out_q | wdata;
          8'h34: out_q <= out_q & ~wdata;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    val      = '0;
    unmapped = 1'b0;
    case (addr_q)
      8'h00: val = data;
      8'h04: val = out_q;
      8'h08: val = pu_q;
      8'h0C: val = pd_q;
      8'h10: val = oe_q;
      8'h14: val = im_q;
      8'h18: val = is_q;
      8'h1C: val = iev_q;
      8'h20: val = ibe_q;
      8'h24: val = ris;
      8'h28: val = mis;
      8'h2C, 8'h30, 8'h34: val = '0;
      default: unmapped = 1'b1;
    endcase
    rdata         = '0;
    rdata[SZ-1:0] = val;
    if (unmapped) rdata = 32'hDEAD_BEEF;
  end

  assign ahb.HRDATA    = rdata;
  assign ahb.HREADYOUT = 1'b1;
  assign IRQ           = irq_q;
  assign GPIO_DOUT     = out_q;
  assign GPIO_PU       = pu_q;
  assign GPIO_PD       = pd_q;
  assign GPIO_OE       = oe_q;
endmodule
